// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - multi-digit seven-segment controller with hex/decimal rendering
//
// Accepts a binary value over a valid/ready handshake and shows it on
// NUM_DIGITS active-low seven-segment digits, either as hex or as decimal.
// Decimal conversion uses a sequential double-dabble converter, one bit per clock.
// Also provides leading-zero suppression, overflow dashes and per-digit blink.
//
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous reset, active low
//   valid_i  new value offered on data_i
//   ready_o  controller idle; a value is accepted when valid_i & ready_o
//   data_i   binary value to display
//   mode_i   0 = hex, 1 = decimal (sampled on accept)
//   lzs_i    leading-zero suppression (sampled on accept)
//   blink_i  per-digit blink mask (live)
//   ovf_o    last accepted value was not representable
//   seg_o    digit d = seg_o[7d+6:7d], bit0 = a .. bit6 = g, 0 = segment lit
module seg7_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [DATA_W-1:0]       data_i,
    input  logic                    mode_i,
    input  logic                    lzs_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    output logic                    ovf_o,
    output logic [7*NUM_DIGITS-1:0] seg_o
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int EXT_W  = (DATA_W > BCD_W) ? DATA_W : BCD_W;
    localparam int ITER_W = $clog2(DATA_W + 1);
    localparam int BLK_W  = $clog2(BLINK_DIV);
    localparam logic [63:0] DEC_MAX = 64'(10 ** NUM_DIGITS) - 64'd1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t                  state_q;
    logic [DATA_W-1:0]       data_q;
    logic                    mode_q;
    logic                    lzs_q;
    logic [DATA_W-1:0]       bin_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [ITER_W-1:0]       iter_q;
    logic [7*NUM_DIGITS-1:0] digits_q;
    logic                    ovf_q;
    logic                    ready_q;
    logic [BLK_W-1:0]        blk_cnt_q;
    logic                    phase_q;

    logic [EXT_W-1:0]        data_ext;
    logic [BCD_W-1:0]        hex_val;
    logic [BCD_W-1:0]        nibbles;
    logic [BCD_W-1:0]        bcd_adj;
    logic                    hex_ovf;
    logic                    dec_ovf;
    logic                    new_ovf;
    logic [7*NUM_DIGITS-1:0] new_digits;
    logic                    seen_nonzero;
    logic [3:0]              nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (b[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = b[4*d +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_comb begin
        data_ext = EXT_W'(data_q);
        // Nibbles beyond DATA_W read as zero through the zero extension.
        hex_val  = data_ext[BCD_W-1:0];
        hex_ovf  = |(data_ext >> BCD_W);
        dec_ovf  = 64'(data_q) > DEC_MAX;
        new_ovf  = mode_q ? dec_ovf : hex_ovf;
        nibbles  = mode_q ? bcd_q : hex_val;
        bcd_adj  = add3(bcd_q);
    end

    // Scan from the most significant digit down; a digit is a leading zero
    // until the first nonzero nibble has been seen. Digit 0 is never blanked.
    always_comb begin
        new_digits   = '1;
        seen_nonzero = 1'b0;
        nib          = 4'h0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nib = nibbles[4*d +: 4];
            if (nib != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            if (new_ovf) begin
                new_digits[7*d +: 7] = SEG_DASH;
            end else if (lzs_q && !seen_nonzero && (d != 0)) begin
                new_digits[7*d +: 7] = SEG_BLANK;
            end else begin
                new_digits[7*d +: 7] = hex_to_seg(nib);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mode_q    <= 1'b0;
            lzs_q     <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            digits_q  <= '1;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b1;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else begin
            if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blk_cnt_q <= '0;
                phase_q   <= ~phase_q;
            end else begin
                blk_cnt_q <= blk_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        data_q  <= data_i;
                        mode_q  <= mode_i;
                        lzs_q   <= lzs_i;
                        bin_q   <= data_i;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= mode_i ? CONV : LOAD;
                    end
                end
                CONV: begin
                    // Shift {bcd, bin} left by one; BCD bits above the top
                    // digit fall off, overflow comes from the compare instead.
                    bcd_q  <= (bcd_adj << 1) | BCD_W'(bin_q[DATA_W-1]);
                    bin_q  <= bin_q << 1;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == ITER_W'(DATA_W - 1)) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    digits_q <= new_digits;
                    ovf_q    <= new_ovf;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        seg_o = digits_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (phase_q && blink_i[d]) begin
                seg_o[7*d +: 7] = SEG_BLANK;
            end
        end
    end

    assign ready_o = ready_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

    localparam int ND = 6;
    localparam int DW = 20;
    localparam int BD = 4;
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
    localparam logic [41:0] ALL_DASH  = {6{7'h3F}};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          mode;
    logic          lzs;
    logic [ND-1:0] blink;
    logic          ovf;
    logic [41:0]   seg;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    seg7_display_ctrl #(
        .NUM_DIGITS(ND),
        .DATA_W    (DW),
        .BLINK_DIV (BD)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .valid_i(valid),
        .ready_o(ready),
        .data_i (data),
        .mode_i (mode),
        .lzs_i  (lzs),
        .blink_i(blink),
        .ovf_o  (ovf),
        .seg_o  (seg)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; blink phase = (edge_n / BD) % 2.
    always @(posedge clk) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          mode;
        logic          lzs;
        logic [41:0]   seg;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [41:0] seg;
        logic        ovf;
        int          lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one value, push its expectation, wait for the controller to go
    // idle again, then pop and compare result and latency.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        exp_t        got;
        int          cyc;
        logic        hold_ok;
        logic [41:0] prev;
        check($sformatf("ready_before[%0d]", idx), ready, 1);
        data  = v.data;
        mode  = v.mode;
        lzs   = v.lzs;
        valid = 1'b1;
        e.seg = v.seg;
        e.ovf = v.ovf;
        e.lat = v.mode ? DW + 1 : 1;
        sb.push_back(e);
        prev    = seg;
        hold_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        data  = DW'($urandom);
        mode  = 1'($urandom);
        lzs   = 1'($urandom);
        cyc   = 0;
        while (!ready && cyc < 100) begin
            if (seg !== prev) hold_ok = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        got = sb.pop_front();
        check($sformatf("hold[%0d]", idx), hold_ok, 1);
        check($sformatf("latency[%0d]", idx), cyc, got.lat);
        check($sformatf("seg[%0d]", idx), seg, got.seg);
        check($sformatf("ovf[%0d]", idx), ovf, got.ovf);
    endtask

    initial begin
        int          cyc;
        logic [41:0] exp_seg;
        logic [6:0]  d0;

        vecs[0]  = '{20'h000A3, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h30}, 1'b0};
        vecs[1]  = '{20'd123456, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0};
        vecs[2]  = '{20'd1000000, 1'b1, 1'b0, ALL_DASH, 1'b1};
        vecs[3]  = '{20'h00000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[4]  = '{20'hFFFFF, 1'b0, 1'b0, {7'h40, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 1'b0};
        vecs[5]  = '{20'h00000, 1'b0, 1'b0, {6{7'h40}}, 1'b0};
        vecs[6]  = '{20'd999999, 1'b1, 1'b1, {6{7'h10}}, 1'b0};
        vecs[7]  = '{20'd0, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
        vecs[8]  = '{20'd1048575, 1'b1, 1'b1, ALL_DASH, 1'b1};
        vecs[9]  = '{20'h10203, 1'b0, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30}, 1'b0};
        vecs[10] = '{20'd405, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h40, 7'h12}, 1'b0};
        vecs[11] = '{20'hBCDE7, 1'b0, 1'b0, {7'h40, 7'h03, 7'h46, 7'h21, 7'h06, 7'h78}, 1'b0};

        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        mode  = 1'b0;
        lzs   = 1'b0;
        blink = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_seg", seg, ALL_BLANK);
        check("reset_ready", ready, 1);
        check("reset_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Blink: hex 5 on digit 0, mask bit 0 only.
        run_vec('{20'h5, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12}, 1'b0}, 12);
        blink = 6'b000001;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d0 = (((edge_n / BD) % 2) == 1) ? 7'h7F : 7'h12;
            exp_seg = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, d0};
            check($sformatf("blink[%0d]", k), seg, exp_seg);
        end
        blink = '0;
        @(negedge clk);

        // valid pulsed mid-conversion must be ignored.
        data  = 20'd123456;
        mode  = 1'b1;
        lzs   = 1'b0;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        cyc   = 0;
        repeat (5) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        data  = 20'h00999;
        mode  = 1'b0;
        lzs   = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        valid = 1'b0;
        check("midconv_ready_low", ready, 0);
        while (!ready && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("midconv_latency", cyc, DW + 1);
        check("midconv_seg", seg, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        check("midconv_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        check("midconv_no_queue_ready", ready, 1);
        check("midconv_no_queue_seg", seg, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

        // Reset in the middle of a conversion, with ovf_o set beforehand.
        run_vec(vecs[2], 13);
        data  = 20'd654321;
        mode  = 1'b1;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_seg", seg, ALL_BLANK);
        check("rst_mid_ready", ready, 1);
        check("rst_mid_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("rst_abort_seg", seg, ALL_BLANK);
        check("rst_abort_ready", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
